// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand resolution feeding the ALU.
// Build option EX_FORWARD_EN: forward from EX/MEM and MEM/WB (stall only on load-use); otherwise stall until writeback.
module ex_operand_stage #(
  parameter int DATA_W  = 8,
  parameter int RADDR_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               IdValid,
  input  logic [RADDR_W-1:0] IdRsA,
  input  logic [RADDR_W-1:0] IdRsB,
  input  logic               IdUseA,
  input  logic               IdUseB,
  input  logic [DATA_W-1:0]  IdDataA,
  input  logic [DATA_W-1:0]  IdDataB,
  input  logic [DATA_W-1:0]  IdImm,
  input  logic               IdALUSrc,
  input  logic [3:0]         IdALUControl,
  input  logic [RADDR_W-1:0] IdRd,
  input  logic               IdRegWrite,
  input  logic               IdMemRead,
  input  logic               IdMemWrite,
  input  logic               Flush,
  input  logic [RADDR_W-1:0] MemRd,
  input  logic               MemRegWrite,
  input  logic [DATA_W-1:0]  MemResult,
  input  logic [RADDR_W-1:0] WbRd,
  input  logic               WbRegWrite,
  input  logic [DATA_W-1:0]  WbData,
  output logic [DATA_W-1:0]  SrcA,
  output logic [DATA_W-1:0]  SrcB,
  output logic [3:0]         ALUControl,
  output logic [DATA_W-1:0]  ExStoreData,
  output logic [RADDR_W-1:0] ExRd,
  output logic               ExValid,
  output logic               ExRegWrite,
  output logic               ExMemRead,
  output logic               ExMemWrite,
  output logic               Stall
);
  localparam int NUM_OPS = 2;

  typedef struct packed {
    logic       vld;
    logic       rw;
    logic       mr;
    logic       mw;
    logic [3:0] alu;
  } ctl_t;

  ctl_t                             r_ctl;
  logic [RADDR_W-1:0]               r_rd;
  logic [NUM_OPS-1:0][RADDR_W-1:0]  r_rs;
  logic [NUM_OPS-1:0][DATA_W-1:0]   r_data;
  logic [DATA_W-1:0]                r_imm;
  logic                             r_alusrc;

  logic [NUM_OPS-1:0][RADDR_W-1:0]  w_id_rs;
  logic [NUM_OPS-1:0]               w_id_use;
  logic [NUM_OPS-1:0][DATA_W-1:0]   w_fwd;
  logic [NUM_OPS-1:0]               w_hit;
  logic                             w_stall;
  logic                             w_bubble;

  assign w_id_rs  = {IdRsB, IdRsA};
  assign w_id_use = {IdUseB, IdUseA};

  // Gated by reset so a held-low reset never requests a stall from live upstream inputs.
  assign w_stall  = rst_n & IdValid & (|w_hit);
  assign w_bubble = Flush | w_stall | ~IdValid;

  // Bubbles clear only control; operand fields keep their last loaded values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctl    <= '0;
      r_rd     <= '0;
      r_rs     <= '0;
      r_data   <= '0;
      r_imm    <= '0;
      r_alusrc <= 1'b0;
    end else if (w_bubble) begin
      r_ctl    <= '0;
    end else begin
      r_ctl    <= {1'b1, IdRegWrite, IdMemRead, IdMemWrite, IdALUControl};
      r_rd     <= IdRd;
      r_rs     <= w_id_rs;
      r_data   <= {IdDataB, IdDataA};
      r_imm    <= IdImm;
      r_alusrc <= IdALUSrc;
    end
  end

`ifdef EX_FORWARD_EN
  logic w_ex_load;
  assign w_ex_load = r_ctl.vld & r_ctl.mr & (r_rd != '0);
`else
  logic w_ex_wr;
  logic w_unused_fwd;
  assign w_ex_wr      = r_ctl.vld & r_ctl.rw;
  assign w_unused_fwd = ^{MemResult, WbRd, WbRegWrite, WbData};
`endif

  // One lane per operand: A = index 0, B = index 1.
  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    logic [DATA_W-1:0] w_val;
`ifdef EX_FORWARD_EN
    assign w_val = (r_rs[g] == '0)                     ? '0        :
                   (MemRegWrite && (MemRd == r_rs[g])) ? MemResult :
                   (WbRegWrite  && (WbRd  == r_rs[g])) ? WbData    :
                                                         r_data[g];
    assign w_hit[g] = w_id_use[g] & w_ex_load & (w_id_rs[g] == r_rd);
`else
    assign w_val = (r_rs[g] == '0) ? '0 : r_data[g];
    // Register file is write-before-read, so only EX and MEM producers block.
    assign w_hit[g] = w_id_use[g] & (w_id_rs[g] != '0) &
                      ((w_ex_wr & (w_id_rs[g] == r_rd)) |
                       (MemRegWrite & (w_id_rs[g] == MemRd)));
`endif
    assign w_fwd[g] = w_val;
  end

  assign SrcA        = w_fwd[0];
  assign SrcB        = r_alusrc ? r_imm : w_fwd[1];
  assign ExStoreData = w_fwd[1];
  assign ALUControl  = r_ctl.alu;
  assign ExRd        = r_rd;
  assign ExValid     = r_ctl.vld;
  assign ExRegWrite  = r_ctl.rw;
  assign ExMemRead   = r_ctl.mr;
  assign ExMemWrite  = r_ctl.mw;
  assign Stall       = w_stall;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: stimulus queues expectations per cycle, a negedge monitor checks them.
module tb_ex_operand_stage;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       IdValid, IdUseA, IdUseB, IdALUSrc, IdRegWrite, IdMemRead, IdMemWrite, Flush;
  logic [2:0] IdRsA, IdRsB, IdRd, MemRd, WbRd;
  logic [7:0] IdDataA, IdDataB, IdImm, MemResult, WbData;
  logic [3:0] IdALUControl;
  logic       MemRegWrite, WbRegWrite;
  logic [7:0] SrcA, SrcB, ExStoreData;
  logic [3:0] ALUControl;
  logic [2:0] ExRd;
  logic       ExValid, ExRegWrite, ExMemRead, ExMemWrite, Stall;

  ex_operand_stage #(.DATA_W(8), .RADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .IdValid(IdValid), .IdRsA(IdRsA), .IdRsB(IdRsB),
    .IdUseA(IdUseA), .IdUseB(IdUseB), .IdDataA(IdDataA), .IdDataB(IdDataB), .IdImm(IdImm),
    .IdALUSrc(IdALUSrc), .IdALUControl(IdALUControl), .IdRd(IdRd), .IdRegWrite(IdRegWrite),
    .IdMemRead(IdMemRead), .IdMemWrite(IdMemWrite), .Flush(Flush), .MemRd(MemRd),
    .MemRegWrite(MemRegWrite), .MemResult(MemResult), .WbRd(WbRd), .WbRegWrite(WbRegWrite),
    .WbData(WbData), .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl),
    .ExStoreData(ExStoreData), .ExRd(ExRd), .ExValid(ExValid), .ExRegWrite(ExRegWrite),
    .ExMemRead(ExMemRead), .ExMemWrite(ExMemWrite), .Stall(Stall)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int F_SRCA = 0, F_SRCB = 1, F_ALU = 2, F_STORE = 3, F_RD = 4;
  localparam int F_VALID = 5, F_RW = 6, F_MR = 7, F_MW = 8, F_STALL = 9, NF = 10;

  typedef struct {
    int         cyc;
    int         fld;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [7:0] act(input int f);
    case (f)
      F_SRCA:  return SrcA;
      F_SRCB:  return SrcB;
      F_ALU:   return {4'b0, ALUControl};
      F_STORE: return ExStoreData;
      F_RD:    return {5'b0, ExRd};
      F_VALID: return {7'b0, ExValid};
      F_RW:    return {7'b0, ExRegWrite};
      F_MR:    return {7'b0, ExMemRead};
      F_MW:    return {7'b0, ExMemWrite};
      default: return {7'b0, Stall};
    endcase
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      n_cmp++;
      if (e.cyc != cyc) begin
        n_bad++;
        $display("FAIL %s: not sampled in its cycle, want %0h", e.name, e.val);
      end else if (act(e.fld) !== e.val) begin
        n_bad++;
        $display("FAIL %s: got %0h want %0h", e.name, act(e.fld), e.val);
      end
    end
  end

  task automatic chk(input int f, input logic [7:0] v, input string nm);
    exp_t x;
    x.cyc = cyc; x.fld = f; x.val = v; x.name = nm;
    q.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    IdValid = 0; IdRsA = 0; IdRsB = 0; IdUseA = 0; IdUseB = 0; IdDataA = 0; IdDataB = 0;
    IdImm = 0; IdALUSrc = 0; IdALUControl = 0; IdRd = 0; IdRegWrite = 0; IdMemRead = 0;
    IdMemWrite = 0; Flush = 0;
  endtask

  task automatic pipe(input logic [2:0] mrd, input logic mwe, input logic [7:0] mres,
                      input logic [2:0] wrd, input logic wwe, input logic [7:0] wdat);
    MemRd = mrd; MemRegWrite = mwe; MemResult = mres;
    WbRd = wrd; WbRegWrite = wwe; WbData = wdat;
  endtask

  task automatic id(input logic [2:0] ra, input logic ua, input logic [7:0] da,
                    input logic [2:0] rb, input logic ub, input logic [7:0] db,
                    input logic as, input logic [7:0] imm, input logic [3:0] alu,
                    input logic [2:0] rd, input logic rw, input logic mr, input logic mw);
    IdValid = 1; IdRsA = ra; IdUseA = ua; IdDataA = da; IdRsB = rb; IdUseB = ub; IdDataB = db;
    IdALUSrc = as; IdImm = imm; IdALUControl = alu; IdRd = rd; IdRegWrite = rw;
    IdMemRead = mr; IdMemWrite = mw;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, want finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    pipe(0, 0, 0, 0, 0, 0);
    // Busy upstream during reset, including a would-be hazard.
    IdValid = 1; IdRsA = 1; IdUseA = 1; IdRsB = 3'($urandom_range(0, 7)); IdUseB = 1;
    IdDataA = 8'($urandom); IdDataB = 8'($urandom); IdImm = 8'($urandom);
    IdALUControl = 4'hF; IdRd = 3; IdRegWrite = 1; IdMemRead = 1; IdMemWrite = 1;
    MemRegWrite = 1; MemRd = 1;
    step(); step();
    for (int f = 0; f < NF; f++) chk(f, 8'h00, $sformatf("reset_f%0d", f));
    step();

    rst_n = 1;
    pipe(0, 0, 0, 0, 0, 0);
    id(1, 1, 8'h05, 2, 1, 8'h03, 0, 8'h00, 4'b1000, 4, 1, 0, 0);
    chk(F_STALL, 0, "add_nostall");
    step();
    chk(F_SRCA, 8'h05, "add_srcA");
    chk(F_SRCB, 8'h03, "add_srcB");
    chk(F_ALU, 8'h08, "add_alu");
    chk(F_VALID, 1, "add_valid");
    chk(F_RD, 4, "add_rd");
    chk(F_RW, 1, "add_rw");
    chk(F_STORE, 8'h03, "add_store");

`ifndef EX_FORWARD_EN
    id(4, 1, 8'h09, 2, 1, 8'h03, 0, 0, 4'b1000, 5, 1, 0, 0);
    chk(F_STALL, 1, "nf_stall_ex");
    step();
    pipe(4, 1, 8'h0C, 0, 0, 0);
    chk(F_STALL, 1, "nf_stall_mem");
    chk(F_VALID, 0, "nf_bubble1_vld");
    chk(F_ALU, 0, "nf_bubble1_alu");
    step();
    pipe(0, 0, 0, 4, 1, 8'h0C);
    chk(F_STALL, 0, "nf_wb_nostall");
    chk(F_VALID, 0, "nf_bubble2_vld");
    step();
    pipe(4, 1, 8'h0C, 4, 1, 8'h0D);
    clr();
    chk(F_SRCA, 8'h09, "nf_no_forward");
    chk(F_VALID, 1, "nf_add2_valid");
    chk(F_RD, 5, "nf_add2_rd");
    step();

    pipe(0, 0, 0, 0, 0, 0);
    id(5, 0, 8'h11, 5, 0, 8'h22, 0, 0, 4'b0010, 6, 0, 0, 0);
    chk(F_STALL, 0, "nf_unused_src");
    step();
    chk(F_ALU, 8'h02, "nf_unused_alu");
    pipe(0, 1, 8'h99, 0, 0, 0);
    id(0, 1, 8'h55, 3, 1, 8'h66, 1, 8'h04, 4'b0011, 7, 0, 0, 0);
    chk(F_STALL, 0, "nf_r0_nostall");
    step();
    chk(F_SRCA, 8'h00, "r0_srcA");
    chk(F_SRCB, 8'h04, "imm_srcB");
    chk(F_STORE, 8'h66, "store_raw");
    chk(F_ALU, 8'h03, "r0_alu");

    pipe(0, 0, 0, 0, 0, 0);
    id(1, 1, 8'h01, 2, 1, 8'h02, 0, 0, 4'b0101, 1, 1, 0, 0);
    Flush = 1;
    step();
    chk(F_VALID, 0, "flush_vld");
    chk(F_ALU, 0, "flush_alu");
    chk(F_RW, 0, "flush_rw");
    Flush = 0;
    id(0, 0, 0, 0, 0, 0, 0, 0, 4'b0110, 2, 1, 0, 1);
    IdValid = 0;
    step();
    chk(F_VALID, 0, "novalid_vld");
    chk(F_MW, 0, "novalid_mw");
    chk(F_ALU, 0, "novalid_alu");

    id(0, 0, 0, 0, 0, 0, 0, 0, 4'b1000, 3, 1, 1, 0);
    step();
    chk(F_MR, 1, "load_mr");
    chk(F_RD, 3, "load_rd");
    id(3, 1, 8'h7F, 0, 0, 0, 0, 0, 4'b1001, 2, 1, 0, 0);
    Flush = 1;
    chk(F_STALL, 1, "flush_stall");
    step();
    chk(F_VALID, 0, "flush_stall_vld");
    chk(F_ALU, 0, "flush_stall_alu");
    Flush = 0;
    pipe(3, 1, 8'h7F, 0, 0, 0);
    chk(F_STALL, 1, "nf_held_stall_mem");
    step();
    pipe(0, 0, 0, 0, 0, 0);
    chk(F_STALL, 0, "nf_held_release");
    step();
    clr();
    chk(F_VALID, 1, "held_vld");
    chk(F_SRCA, 8'h7F, "held_srcA");
    chk(F_ALU, 8'h09, "held_alu");
`else
    id(4, 1, 8'h00, 2, 1, 8'h03, 0, 0, 4'b1000, 5, 1, 0, 0);
    chk(F_STALL, 0, "f_alu_nostall");
    step();
    pipe(4, 1, 8'h2A, 4, 1, 8'h11);
    chk(F_SRCA, 8'h2A, "f_exmem_prio");
    id(4, 1, 8'h00, 0, 0, 0, 0, 0, 4'b1000, 1, 1, 0, 0);
    step();
    pipe(0, 0, 0, 4, 1, 8'h11);
    chk(F_SRCA, 8'h11, "f_memwb");
    id(0, 0, 0, 0, 0, 0, 0, 0, 4'b1000, 3, 1, 1, 0);
    step();
    pipe(0, 0, 0, 0, 0, 0);
    chk(F_MR, 1, "f_load_mr");
    id(3, 1, 8'h00, 0, 0, 0, 0, 0, 4'b1001, 6, 1, 0, 0);
    chk(F_STALL, 1, "f_loaduse_stall");
    step();
    chk(F_VALID, 0, "f_loaduse_vld");
    chk(F_ALU, 0, "f_loaduse_alu");
    chk(F_STALL, 0, "f_loaduse_one_cycle");
    step();
    pipe(3, 1, 8'h7F, 0, 0, 0);
    clr();
    chk(F_SRCA, 8'h7F, "f_loaduse_fwd");
    chk(F_VALID, 1, "f_sub_valid");
    chk(F_ALU, 8'h09, "f_sub_alu");
    id(0, 0, 0, 0, 0, 0, 0, 0, 4'b1000, 5, 1, 1, 0);
    step();
    pipe(0, 0, 0, 0, 0, 0);
    id(5, 1, 8'h00, 0, 0, 0, 0, 0, 4'b0100, 2, 1, 0, 0);
    Flush = 1;
    chk(F_STALL, 1, "f_flush_stall");
    step();
    Flush = 0;
    chk(F_VALID, 0, "f_flush_bubble");
    chk(F_STALL, 0, "f_flush_nostall");
    step();
    chk(F_VALID, 1, "f_held_load");
    chk(F_ALU, 8'h04, "f_held_alu");
    pipe(0, 1, 8'h99, 2, 1, 8'h33);
    id(0, 1, 8'h55, 2, 1, 8'h10, 1, 8'h04, 4'b0011, 7, 0, 0, 0);
    step();
    chk(F_SRCA, 8'h00, "f_r0");
    chk(F_SRCB, 8'h04, "f_imm");
    chk(F_STORE, 8'h33, "f_store_fwd");
    clr();
`endif

    step();
    pipe(0, 0, 0, 0, 0, 0);
    step();
    step();
    if (q.size() != 0) begin
      n_bad += q.size();
      $display("FAIL drain: %0d expectations never sampled, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
